modrm_addr_decoder: RTL
=======================

# modrm_addr_decoder

Parametrised, sequential ModR/M addressing-form decoder for the S186 front end, extended to 386-style 32-bit addressing. It accepts a start request and pulls the ModR/M byte, an optional SIB byte and 0/1/2/4 displacement bytes from the prefetch byte stream. It then computes the effective address from the GPR file and returns the decoded fields through a valid/ready handshake. It sits between the prefetch queue and the microcode sequencer.

## Interface
Parameters:
- SUPPORT_32, 1: 1 enables the 32-bit addressing forms; 0 forces 16-bit forms, ignores addr32 and makes effective_address[31:16] constant 0.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a decode; accepted only in IDLE.
- addr32  in  1  address-size mode for this decode; sampled when start is accepted.
- clear  in  1  synchronous abort; returns to IDLE from any state.
- byte_valid  in  1  prefetch byte available.
- byte_data  in  8  prefetch byte.
- byte_ready  out  1  byte consumed this cycle when high together with byte_valid.
- gpr  in  256  GPR read view, gpr[32*i +: 32], with i = 0 to 7 for EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI.
- out_valid  out  1  result fields valid.
- out_ready  in  1  consumer accepts the result.
- effective_address  out  32  computed EA.
- regnum  out  3  ModR/M reg field.
- rm_regnum  out  3  ModR/M rm field.
- rm_is_reg  out  1  mod == 11.
- ss_default  out  1  the addressing form defaults to the SS segment.
- length  out  3  bytes consumed, counting ModR/M + SIB + displacement (1 to 6).
- busy  out  1  state is not IDLE.

## Operation
- Reset sets state to IDLE and drives every output to 0.
- States:
  - IDLE: on start, latch addr32 and go to MODRM.
  - MODRM: byte_ready = 1. On a handshake, latch the byte and select the next state:
    - SIB when mode32, mod != 11 and rm == 100;
    - otherwise DISP when disp_len > 0;
    - otherwise CALC.
  - SIB: byte_ready = 1. On a handshake, latch the byte and go to DISP when disp_len > 0, else CALC.
  - DISP: byte_ready = 1. Accept bytes little-endian into a 32-bit displacement register using a byte counter. Go to CALC after the last byte.
  - CALC: sample gpr, compute the EA and register all result fields. Go to OUT.
  - OUT: out_valid = 1 and the fields are held stable. On out_ready go to IDLE.
- In every other state byte_ready = 0.
- mode32 = SUPPORT_32 & latched addr32.
- 16-bit displacement length:
  - mod 00 with rm 110: 2;
  - mod 01: 1;
  - mod 10: 2;
  - otherwise: 0.
- 16-bit EA uses the low 16 bits of the GPRs, with the same rm table as the existing 8086 form:
  - rm 000 to 111 select BX+SI, BX+DI, BP+SI, BP+DI, SI, DI, BP, BX, in that order;
  - mod 00 with rm 110 uses disp16 only;
  - the result is taken modulo 2^16 and zero-extended.
- 32-bit displacement length:
  - mod 01: 1;
  - mod 10: 4;
  - mod 00 with rm 101: 4;
  - mod 00 with SIB base 101: 4;
  - otherwise: 0.
- 32-bit EA:
  - base = gpr[rm], or gpr[SIB.base] when a SIB byte is present;
  - with mod 00, rm 101 has no base;
  - with mod 00, SIB base 101 has no base;
  - index = gpr[SIB.index] shifted left by SIB.ss, and is 0 when SIB.index == 100;
  - EA = base + index + disp, modulo 2^32.
- disp8 is always sign-extended to the active address width.
- ss_default:
  - 16-bit: set for rm 010 or 011 with mod != 11, or rm 110 with mod 01/10.
  - 32-bit: set when the base register is ESP or EBP and a base is present.
- mod 11: effective_address = 0, rm_is_reg = 1, ss_default = 0, length = 1.
- clear has priority over start and over any handshake in the same cycle. A byte offered in the clear cycle is not consumed (byte_ready = 0).
- start outside IDLE is ignored.
- Result outputs keep their last values in IDLE until the next CALC.

## Timing
- start accepted in cycle N puts the block in MODRM at N+1.
- With byte_valid held high, one byte is consumed per cycle. CALC follows the last byte, and out_valid rises the cycle after CALC.
- Minimum latency, for mod 11: start at N, ModR/M consumed at N+1, CALC at N+2, out_valid at N+3.
- Worst case, for the 32-bit SIB + disp32 form: out_valid at N+8.
- byte_valid gaps stall the current state without any other effect.
- out_ready low holds OUT indefinitely. The earliest next start is the cycle after the out_ready handshake.
- Reset asserted mid-operation returns the block to IDLE immediately, with all outputs 0.

## Test plan
- 16-bit `mod01 rm110`:
  - Stimulus: ModR/M 0x46, disp 0xFE, BP = 0x1000.
  - Required: EA 0x0FFE, ss_default 1, regnum 0, length 2, out_valid at N+4.
- 16-bit wrap:
  - Stimulus: ModR/M 0x00, BX = 0xFFFF, SI = 0x0002.
  - Required: EA 0x00000001, ss_default 0, length 1.
- 32-bit SIB:
  - Stimulus: ModR/M 0x04, SIB 0x88, EAX = 0x100, ECX = 0x10.
  - Required: EA 0x140, length 2.
  - Repeat with SIB 0x24 and ESP = 0x2000: required EA 0x2000, ss_default 1.
- 32-bit disp32:
  - Stimulus: ModR/M 0x05, bytes 78 56 34 12, with byte_valid low for 2 cycles between bytes 2 and 3.
  - Required: EA 0x12345678, length 5, no byte lost or duplicated.
- Handshake and abort:
  - Hold out_ready low for 5 cycles; required: fields stable and start ignored.
  - Pulse clear while in DISP; required: IDLE next cycle with the pending byte not consumed, then a fresh decode completes correctly.
- SUPPORT_32 = 0 build:
  - Stimulus: addr32 = 1, ModR/M 0x04.
  - Required: decoded as 16-bit SI, EA = SI, length 1.

Source files
------------

// File: rtl/modrm_addr_decoder_if.sv
// Bus bundle for the ModR/M addressing-form decoder: start/abort control,
// prefetch byte stream, GPR read view and the decoded result.
interface modrm_addr_decoder_if;
  logic         start;
  logic         addr32;
  logic         clear;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic [255:0] gpr;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  effective_address;
  logic [2:0]   regnum;
  logic [2:0]   rm_regnum;
  logic         rm_is_reg;
  logic         ss_default;
  logic [2:0]   length;
  logic         busy;

  // Handshakes: a byte transfers on a rising clk edge where byte_valid && byte_ready;
  // a result transfers where out_valid && out_ready. byte_ready and out_valid depend
  // only on decoder state (and clear), never on byte_valid/out_ready.
  modport master (
    output start, addr32, clear, byte_valid, byte_data, gpr, out_ready,
    input  byte_ready, out_valid, effective_address, regnum, rm_regnum,
           rm_is_reg, ss_default, length, busy
  );

  modport slave (
    input  start, addr32, clear, byte_valid, byte_data, gpr, out_ready,
    output byte_ready, out_valid, effective_address, regnum, rm_regnum,
           rm_is_reg, ss_default, length, busy
  );
endinterface

// File: rtl/modrm_addr_decoder.sv
// Sequential ModR/M (+SIB, +displacement) decoder producing the effective
// address and register fields for 16-bit and 386-style 32-bit addressing.
module modrm_addr_decoder #(
  parameter bit SUPPORT_32 = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  modrm_addr_decoder_if.slave   bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MODRM = 3'd1,
    S_SIB   = 3'd2,
    S_DISP  = 3'd3,
    S_CALC  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t      state, state_next;
  logic        mode32;
  logic [7:0]  modrm_q;
  logic [7:0]  sib_q;
  logic        has_sib;
  logic [2:0]  disp_len;
  logic [1:0]  disp_cnt;
  logic [31:0] disp_q;
  logic        byte_ready_c;
  logic [2:0]  dl_new;
  logic        take;
  logic        disp_last;

  logic [31:0] ea_q;
  logic [2:0]  regnum_q;
  logic [2:0]  rm_q;
  logic        rm_is_reg_q;
  logic        ss_q;
  logic [2:0]  len_q;

  function automatic logic [2:0] dl16(input logic [1:0] md, input logic [2:0] rm);
    if (md == 2'b00 && rm == 3'b110) return 3'd2;
    else if (md == 2'b01)            return 3'd1;
    else if (md == 2'b10)            return 3'd2;
    else                             return 3'd0;
  endfunction

  // b is the rm field, or SIB.base when a SIB byte is present
  function automatic logic [2:0] dl32(input logic [1:0] md, input logic [2:0] b);
    if (md == 2'b01)                     return 3'd1;
    else if (md == 2'b10)                return 3'd4;
    else if (md == 2'b00 && b == 3'b101) return 3'd4;
    else                                 return 3'd0;
  endfunction

  assign take      = byte_ready_c & bus.byte_valid;
  assign disp_last = (({1'b0, disp_cnt} + 3'd1) == disp_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    byte_ready_c = 1'b0;
    dl_new       = 3'd0;
    case (state)
      S_MODRM: dl_new = mode32 ? dl32(bus.byte_data[7:6], bus.byte_data[2:0])
                               : dl16(bus.byte_data[7:6], bus.byte_data[2:0]);
      S_SIB:   dl_new = dl32(modrm_q[7:6], bus.byte_data[2:0]);
      default: dl_new = 3'd0;
    endcase
    if (bus.clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state_next = S_MODRM;
        S_MODRM: begin
          byte_ready_c = 1'b1;
          if (bus.byte_valid) begin
            if (mode32 && bus.byte_data[7:6] != 2'b11 && bus.byte_data[2:0] == 3'b100)
              state_next = S_SIB;
            else if (dl_new != 3'd0)
              state_next = S_DISP;
            else
              state_next = S_CALC;
          end
        end
        S_SIB: begin
          byte_ready_c = 1'b1;
          if (bus.byte_valid) state_next = (dl_new != 3'd0) ? S_DISP : S_CALC;
        end
        S_DISP: begin
          byte_ready_c = 1'b1;
          if (bus.byte_valid && disp_last) state_next = S_CALC;
        end
        S_CALC:  state_next = S_OUT;
        S_OUT:   if (bus.out_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Effective-address arithmetic, evaluated from latched bytes and the live GPR view
  logic [31:0] gr [8];
  logic [1:0]  md;
  logic [2:0]  rm_f;
  logic [15:0] base16, disp16, ea16;
  logic        ss16;
  logic [2:0]  b_idx;
  logic        base_en;
  logic [31:0] base32, index32, disp32, ea32;
  logic        ss32;
  logic [31:0] res_ea;
  logic        res_ss;
  logic        res_is_reg;
  logic [2:0]  res_len;

  always_comb begin
    for (int i = 0; i < 8; i++) gr[i] = bus.gpr[32*i +: 32];
    md   = modrm_q[7:6];
    rm_f = modrm_q[2:0];

    case (rm_f)
      3'd0:    base16 = gr[3][15:0] + gr[6][15:0];
      3'd1:    base16 = gr[3][15:0] + gr[7][15:0];
      3'd2:    base16 = gr[5][15:0] + gr[6][15:0];
      3'd3:    base16 = gr[5][15:0] + gr[7][15:0];
      3'd4:    base16 = gr[6][15:0];
      3'd5:    base16 = gr[7][15:0];
      3'd6:    base16 = (md == 2'b00) ? 16'h0000 : gr[5][15:0];
      default: base16 = gr[3][15:0];
    endcase
    disp16 = (disp_len == 3'd1) ? {{8{disp_q[7]}}, disp_q[7:0]} : disp_q[15:0];
    ea16   = base16 + disp16;
    ss16   = (rm_f == 3'd2) || (rm_f == 3'd3) || (rm_f == 3'd6 && md != 2'b00);

    b_idx   = has_sib ? sib_q[2:0] : rm_f;
    base_en = !(md == 2'b00 && b_idx == 3'b101);
    base32  = base_en ? gr[b_idx] : 32'h0;
    index32 = (has_sib && sib_q[5:3] != 3'b100) ? (gr[sib_q[5:3]] << sib_q[7:6]) : 32'h0;
    disp32  = (disp_len == 3'd1) ? {{24{disp_q[7]}}, disp_q[7:0]} : disp_q;
    ea32    = base32 + index32 + disp32;
    ss32    = base_en && (b_idx == 3'd4 || b_idx == 3'd5);

    if (md == 2'b11) begin
      res_ea     = 32'h0;
      res_ss     = 1'b0;
      res_is_reg = 1'b1;
      res_len    = 3'd1;
    end else begin
      res_ea     = mode32 ? ea32 : {16'h0000, ea16};
      res_ss     = mode32 ? ss32 : ss16;
      res_is_reg = 1'b0;
      res_len    = 3'd1 + {2'b00, has_sib} + disp_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode32      <= 1'b0;
      modrm_q     <= 8'h00;
      sib_q       <= 8'h00;
      has_sib     <= 1'b0;
      disp_len    <= 3'd0;
      disp_cnt    <= 2'd0;
      disp_q      <= 32'h0;
      ea_q        <= 32'h0;
      regnum_q    <= 3'd0;
      rm_q        <= 3'd0;
      rm_is_reg_q <= 1'b0;
      ss_q        <= 1'b0;
      len_q       <= 3'd0;
    end else if (!bus.clear) begin
      case (state)
        S_IDLE: if (bus.start) begin
          mode32   <= SUPPORT_32 & bus.addr32;
          has_sib  <= 1'b0;
          disp_len <= 3'd0;
          disp_cnt <= 2'd0;
          disp_q   <= 32'h0;
        end
        S_MODRM: if (take) begin
          modrm_q  <= bus.byte_data;
          disp_len <= dl_new;
        end
        S_SIB: if (take) begin
          sib_q    <= bus.byte_data;
          has_sib  <= 1'b1;
          disp_len <= dl_new;
        end
        S_DISP: if (take) begin
          disp_q[{disp_cnt, 3'b000} +: 8] <= bus.byte_data;
          disp_cnt <= disp_cnt + 2'd1;
        end
        S_CALC: begin
          ea_q        <= res_ea;
          regnum_q    <= modrm_q[5:3];
          rm_q        <= modrm_q[2:0];
          rm_is_reg_q <= res_is_reg;
          ss_q        <= res_ss;
          len_q       <= res_len;
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready        = byte_ready_c;
  assign bus.out_valid         = (state == S_OUT);
  assign bus.busy              = (state != S_IDLE);
  assign bus.effective_address = ea_q;
  assign bus.regnum            = regnum_q;
  assign bus.rm_regnum         = rm_q;
  assign bus.rm_is_reg         = rm_is_reg_q;
  assign bus.ss_default        = ss_q;
  assign bus.length            = len_q;
  assign dbg_state             = state;

endmodule
